// File: rtl/bp_be_stride_prefetch_issuer.sv
// bp_be_stride_prefetch_issuer
//   Takes start/confirm discovery events from the stride detector, queues them
//   and expands each one into a train of prefetch addresses on a valid/ready port.
//   Optional feature macro: BP_BE_PF_LINE_DEDUP_EN suppresses consecutive
//   requests that fall in the same cache block as the last accepted request.
module bp_be_stride_prefetch_issuer #(
    parameter int vaddr_width_p    = 39,
    parameter int stride_width_p   = 8,
    parameter int prefetch_depth_p = 4,
    parameter int fifo_els_p       = 4,
    parameter int block_width_p    = 512
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      start_discovery_i,
    input  logic                      confirm_discovery_i,
    input  logic [vaddr_width_p-1:0]  striding_pc_i,
    input  logic [vaddr_width_p-1:0]  eff_addr_i,
    input  logic [stride_width_p-1:0] stride_i,
    input  logic                      flush_i,
    output logic                      pf_v_o,
    output logic [vaddr_width_p-1:0]  pf_addr_o,
    input  logic                      pf_ready_and_i,
    output logic                      busy_o,
    output logic [7:0]                drop_count_o
);

    localparam int cnt_w_lp = $clog2(prefetch_depth_p + 1);
    localparam int ptr_w_lp = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam int occ_w_lp = $clog2(fifo_els_p + 1);

    typedef struct packed {
        logic [vaddr_width_p-1:0]  pc;
        logic [vaddr_width_p-1:0]  addr;
        logic [stride_width_p-1:0] stride;
        logic [cnt_w_lp-1:0]       cnt;
    } entry_s;

    typedef enum logic {IDLE, ISSUE} state_e;

    function automatic logic [vaddr_width_p-1:0] sext(input logic [stride_width_p-1:0] s);
        return {{(vaddr_width_p-stride_width_p){s[stride_width_p-1]}}, s};
    endfunction

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(fifo_els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Event queue
    // ------------------------------------------------------------------
    entry_s                mem_r [fifo_els_p];
    logic [ptr_w_lp-1:0]   rd_ptr_r, wr_ptr_r;
    logic [occ_w_lp-1:0]   occ_r;
    logic                  empty, full;
    logic                  ev_v, push, pop, drop;
    entry_s                new_entry, head;

    state_e                state_r, state_n;

    assign empty = (occ_r == '0);
    assign full  = (occ_r == occ_w_lp'(fifo_els_p));
    assign head  = mem_r[rd_ptr_r];

    // Zero-stride events carry no useful prediction; flush kills same-cycle events.
    assign ev_v  = (start_discovery_i | confirm_discovery_i) & (|stride_i) & ~flush_i;
    assign pop   = (state_r == IDLE) & ~empty & ~flush_i;
    assign push  = ev_v & (~full | pop);
    assign drop  = ev_v & full & ~pop;

    always_comb begin
        new_entry        = '0;
        new_entry.pc     = striding_pc_i;
        new_entry.addr   = eff_addr_i;
        new_entry.stride = stride_i;
        // Confirm wins when both strobes are high.
        new_entry.cnt    = confirm_discovery_i ? cnt_w_lp'(prefetch_depth_p) : cnt_w_lp'(1);
    end

    // Queue pointers and occupancy; flush empties the queue.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            occ_r    <= '0;
        end else if (flush_i) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            occ_r    <= '0;
        end else begin
            if (push) wr_ptr_r <= ptr_inc(wr_ptr_r);
            if (pop)  rd_ptr_r <= ptr_inc(rd_ptr_r);
            case ({push, pop})
                2'b10:   occ_r <= occ_r + 1'b1;
                2'b01:   occ_r <= occ_r - 1'b1;
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Queue storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk_i) begin
        if (push) mem_r[wr_ptr_r] <= new_entry;
    end

    // Saturating drop counter for events lost to a full queue.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)                      drop_count_o <= '0;
        else if (drop && drop_count_o != 8'hFF) drop_count_o <= drop_count_o + 8'd1;
    end

    // ------------------------------------------------------------------
    // Train expansion
    // ------------------------------------------------------------------
    logic [vaddr_width_p-1:0]  cur_r, cur_n;
    logic [stride_width_p-1:0] stride_r, stride_n;
    logic [cnt_w_lp-1:0]       remain_r, remain_n;
    logic [vaddr_width_p-1:0]  pc_r, pc_n;       // striding PC of the active train, debug visibility
    logic                      hs, step, same_blk;

`ifdef BP_BE_PF_LINE_DEDUP_EN
    localparam int blk_shift_lp = $clog2(block_width_p / 8);
    localparam int blk_w_lp     = vaddr_width_p - blk_shift_lp;
    logic [blk_w_lp-1:0] last_blk_r, last_blk_n;
    logic                last_v_r, last_v_n;
    assign same_blk = (state_r == ISSUE) & last_v_r & (cur_r[vaddr_width_p-1:blk_shift_lp] == last_blk_r);
`else
    assign same_blk = 1'b0;
`endif

    assign pf_v_o    = (state_r == ISSUE) & ~same_blk;
    assign pf_addr_o = cur_r;
    assign hs        = pf_v_o & pf_ready_and_i;
    // A same-block step is consumed internally without a handshake.
    assign step      = hs | same_blk;
    assign busy_o    = ~empty | (state_r != IDLE);

    // Next-state and train datapath.
    always_comb begin
        state_n  = state_r;
        cur_n    = cur_r;
        stride_n = stride_r;
        remain_n = remain_r;
        pc_n     = pc_r;
`ifdef BP_BE_PF_LINE_DEDUP_EN
        last_blk_n = last_blk_r;
        last_v_n   = last_v_r;
        if (hs) begin
            last_blk_n = cur_r[vaddr_width_p-1:blk_shift_lp];
            last_v_n   = 1'b1;
        end
`endif
        case (state_r)
            IDLE: begin
                if (pop) begin
                    cur_n    = head.addr + sext(head.stride);
                    stride_n = head.stride;
                    remain_n = head.cnt;
                    pc_n     = head.pc;
                    state_n  = ISSUE;
                end
            end
            ISSUE: begin
                if (step) begin
                    cur_n    = cur_r + sext(stride_r);
                    remain_n = remain_r - 1'b1;
                    if (remain_r == cnt_w_lp'(1)) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // Flush overrides any handshake in the same cycle.
        if (flush_i) begin
            state_n  = IDLE;
            cur_n    = cur_r;
            remain_n = remain_r;
`ifdef BP_BE_PF_LINE_DEDUP_EN
            last_blk_n = '0;
            last_v_n   = 1'b0;
`endif
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_r <= IDLE;
        else            state_r <= state_n;
    end

    // Train datapath registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cur_r    <= '0;
            stride_r <= '0;
            remain_r <= '0;
            pc_r     <= '0;
        end else begin
            cur_r    <= cur_n;
            stride_r <= stride_n;
            remain_r <= remain_n;
            pc_r     <= pc_n;
        end
    end

`ifdef BP_BE_PF_LINE_DEDUP_EN
    // Last accepted block, used to suppress same-block repeats.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            last_blk_r <= '0;
            last_v_r   <= 1'b0;
        end else begin
            last_blk_r <= last_blk_n;
            last_v_r   <= last_v_n;
        end
    end
`endif

endmodule

// File: tb/tb_bp_be_stride_prefetch_issuer.sv
// Self-checking bench for bp_be_stride_prefetch_issuer: table of single events
// plus hand sequences for stall, overflow, flush and reset mid-train.
module tb_bp_be_stride_prefetch_issuer;

    localparam int VA = 39;
    localparam int SW = 8;

    logic          clk_i = 1'b0;
    logic          reset_n_i = 1'b0;
    logic          start_discovery_i = 1'b0;
    logic          confirm_discovery_i = 1'b0;
    logic [VA-1:0] striding_pc_i = '0;
    logic [VA-1:0] eff_addr_i = '0;
    logic [SW-1:0] stride_i = '0;
    logic          flush_i = 1'b0;
    logic          pf_v_o;
    logic [VA-1:0] pf_addr_o;
    logic          pf_ready_and_i = 1'b0;
    logic          busy_o;
    logic [7:0]    drop_count_o;

    int checks = 0;
    int failures = 0;
    logic [VA-1:0] exp_q [$];

    bp_be_stride_prefetch_issuer dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .start_discovery_i(start_discovery_i), .confirm_discovery_i(confirm_discovery_i),
        .striding_pc_i(striding_pc_i), .eff_addr_i(eff_addr_i), .stride_i(stride_i),
        .flush_i(flush_i), .pf_v_o(pf_v_o), .pf_addr_o(pf_addr_o),
        .pf_ready_and_i(pf_ready_and_i), .busy_o(busy_o), .drop_count_o(drop_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Scoreboard: every accepted request is compared against the queue head.
    always @(negedge clk_i) begin
        if (reset_n_i && pf_v_o && pf_ready_and_i && !flush_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_req: got 0x%0h expected none", pf_addr_o);
            end else begin
                logic [VA-1:0] e;
                e = exp_q.pop_front();
                if (pf_addr_o !== e) begin
                    failures++;
                    $display("FAIL pf_addr: got 0x%0h expected 0x%0h", pf_addr_o, e);
                end
            end
        end
    end

    task automatic push_train(input logic [VA-1:0] first, input logic [SW-1:0] s, input int n);
        logic [VA-1:0] a;
        logic [VA-1:0] sx;
        a  = first;
        sx = {{(VA-SW){s[SW-1]}}, s};
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(a);
            a = a + sx;
        end
    endtask

    // One-cycle event pulse; returns #1 after the edge that captured it.
    task automatic drive_ev(input logic st, input logic cf, input logic [VA-1:0] a, input logic [SW-1:0] s);
        @(posedge clk_i); #1;
        start_discovery_i = st; confirm_discovery_i = cf;
        eff_addr_i = a; stride_i = s; striding_pc_i = a ^ 39'h55;
        @(posedge clk_i); #1;
        start_discovery_i = 1'b0; confirm_discovery_i = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        @(negedge clk_i);
        while (busy_o && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        chk({name, "_idle"}, busy_o, 1'b0);
        chk({name, "_sb_empty"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    typedef struct {
        logic          st;
        logic          cf;
        logic [VA-1:0] addr;
        logic [SW-1:0] stride;
        logic [VA-1:0] exp_first;
        int            exp_n;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int dedup_n;
`ifdef BP_BE_PF_LINE_DEDUP_EN
        dedup_n = 1;
`else
        dedup_n = 4;
`endif
        vecs[0] = '{1'b0, 1'b1, 39'h1000,         8'd64,  39'h1040, 4};
        vecs[1] = '{1'b1, 1'b0, 39'h2000,         8'hF8,  39'h1FF8, 1};
        vecs[2] = '{1'b0, 1'b1, 39'h7F_FFFF_FFC0, 8'd64,  39'h0,    4};
        vecs[3] = '{1'b0, 1'b1, 39'h5000,         8'h80,  39'h4F80, 4};
        vecs[4] = '{1'b1, 1'b1, 39'h6000,         8'd100, 39'h6064, 4};
        vecs[5] = '{1'b0, 1'b1, 39'h3000,         8'd8,   39'h3008, dedup_n};

        // Reset state
        #12;
        chk("rst_pf_v", pf_v_o, 1'b0);
        chk("rst_pf_addr", pf_addr_o, '0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_drop", drop_count_o, 8'd0);
        reset_n_i = 1'b1;
        pf_ready_and_i = 1'b1;

        // Table-driven single events with ready held high
        for (int i = 0; i < 6; i++) begin
            push_train(vecs[i].exp_first, vecs[i].stride, vecs[i].exp_n);
            drive_ev(vecs[i].st, vecs[i].cf, vecs[i].addr, vecs[i].stride);
            @(negedge clk_i);
            chk($sformatf("v%0d_lat_t1", i), pf_v_o, 1'b0);
            @(negedge clk_i);
            chk($sformatf("v%0d_lat_t2", i), pf_v_o, 1'b1);
            wait_idle($sformatf("v%0d", i), 40);
        end

        // Zero stride: discarded without a drop count
        drive_ev(1'b0, 1'b1, 39'h8000, 8'd0);
        @(negedge clk_i);
        chk("zero_stride_busy", busy_o, 1'b0);
        chk("zero_stride_drop", drop_count_o, 8'd0);

        // Stall: start event, ready low, request must hold steady
        pf_ready_and_i = 1'b0;
        push_train(39'h1FF8, 8'hF8, 1);
        drive_ev(1'b1, 1'b0, 39'h2000, 8'hF8);
        @(negedge clk_i);
        @(negedge clk_i);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall%0d_v", k), pf_v_o, 1'b1);
            chk($sformatf("stall%0d_addr", k), pf_addr_o, 39'h1FF8);
            @(negedge clk_i);
        end
        @(posedge clk_i); #1;
        pf_ready_and_i = 1'b1;
        wait_idle("stall", 20);

        // Overflow: 6 back-to-back confirms with ready low
        pf_ready_and_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk_i); #1;
            confirm_discovery_i = 1'b1;
            eff_addr_i = 39'h10000 * (k + 1);
            stride_i = 8'd64;
            if (k < 5) push_train(39'h10000 * (k + 1) + 39'd64, 8'd64, 4);
        end
        @(posedge clk_i); #1;
        confirm_discovery_i = 1'b0;
        @(negedge clk_i);
        chk("ovf_drop", drop_count_o, 8'd1);
        chk("ovf_busy", busy_o, 1'b1);
        chk("ovf_sb_pending", exp_q.size(), 20);
        @(posedge clk_i); #1;
        pf_ready_and_i = 1'b1;
        wait_idle("ovf", 100);

        // Flush mid-train after two accepted; event in flush cycle is discarded
        push_train(39'h9040, 8'd64, 2);
        drive_ev(1'b0, 1'b1, 39'h9000, 8'd64);
        @(negedge clk_i);
        @(negedge clk_i);
        chk("fl_first_v", pf_v_o, 1'b1);
        @(posedge clk_i);
        @(posedge clk_i); #1;
        flush_i = 1'b1;
        confirm_discovery_i = 1'b1; eff_addr_i = 39'hA000; stride_i = 8'd64;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        confirm_discovery_i = 1'b0;
        @(negedge clk_i);
        chk("fl_pf_v", pf_v_o, 1'b0);
        chk("fl_busy", busy_o, 1'b0);
        wait_idle("fl", 5);

        // Reset pulse mid-train after two accepted
        push_train(39'hB040, 8'd64, 2);
        drive_ev(1'b0, 1'b1, 39'hB000, 8'd64);
        @(negedge clk_i);
        @(negedge clk_i);
        @(posedge clk_i);
        @(posedge clk_i); #1;
        reset_n_i = 1'b0;
        #2;
        chk("rm_pf_v", pf_v_o, 1'b0);
        chk("rm_pf_addr", pf_addr_o, '0);
        chk("rm_drop", drop_count_o, 8'd0);
        reset_n_i = 1'b1;
        @(negedge clk_i);
        chk("rm_busy", busy_o, 1'b0);
        wait_idle("rm", 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
